// File: rtl/bat_amateur_pkg.sv
// Shared types for the bat_amateur external load port: FSM states and RW encoding.
package bat_amateur_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_ACK       = 2'd3
    } ext_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/bat_amateur_load_stats.sv
// Word count and running checksum of words committed to RAM through the load port.
module bat_amateur_load_stats #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_inc,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [ADDRESS_WIDTH-1:0] o_word_count,
    output logic [DATA_WIDTH-1:0]    o_checksum
);

    logic [ADDRESS_WIDTH-1:0] r_word_count;
    logic [DATA_WIDTH-1:0]    r_checksum;

    // Clear wins over a same-cycle commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word_count <= '0;
            r_checksum   <= '0;
        end else if (i_clr) begin
            r_word_count <= '0;
            r_checksum   <= '0;
        end else if (i_inc) begin
            r_word_count <= r_word_count + ADDRESS_WIDTH'(1);
            r_checksum   <= r_checksum + i_data;
        end
    end

    assign o_word_count = r_word_count;
    assign o_checksum   = r_checksum;

endmodule

// File: rtl/bat_amateur_ext_port.sv
// RAM-side responder for the external program-load/inspect interface; only serves
// requests while the CPU is halted.
module bat_amateur_ext_port
    import bat_amateur_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_halt,
    input  logic                     i_ext_req,
    input  logic                     i_ext_rw,
    input  logic [ADDRESS_WIDTH-1:0] i_ext_addr,
    input  logic [DATA_WIDTH-1:0]    i_ext_wdata,
    output logic                     o_ext_ack,
    output logic                     o_ext_err,
    output logic [DATA_WIDTH-1:0]    o_ext_rdata,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]    o_ram_wdata,
    output logic                     o_ram_we,
    output logic                     o_ram_oe,
    input  logic [DATA_WIDTH-1:0]    i_ram_rdata,
    input  logic                     i_clr_stats,
    output logic [ADDRESS_WIDTH-1:0] o_word_count,
    output logic [DATA_WIDTH-1:0]    o_checksum,
    output logic                     o_busy
);

    localparam int unsigned LAT_W = 2;

    ext_state_t               r_state;
    logic [LAT_W-1:0]         r_lat_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_ack;
    logic                     r_err;
    logic                     r_we;
    logic                     r_oe;
    logic                     r_busy;
    logic                     w_commit;

    // Strobes default low each cycle so each is a single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_oe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_ext_req) begin
                        r_addr  <= i_ext_addr;
                        r_wdata <= i_ext_wdata;
                        r_busy  <= 1'b1;
                        if (!i_halt) begin
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ST_ACK;
                        end else if (i_ext_rw == RW_WRITE) begin
                            r_we    <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            r_oe      <= 1'b1;
                            r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
                            r_state   <= ST_READ_WAIT;
                        end
                    end
                end
                // The strobe is already committed, so a HALT drop here does not abort.
                ST_WRITE: begin
                    r_ack   <= 1'b1;
                    r_err   <= 1'b0;
                    r_state <= ST_ACK;
                end
                ST_READ_WAIT: begin
                    if (!i_halt) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_ACK;
                    end else if (r_lat_cnt == '0) begin
                        r_rdata <= i_ram_rdata;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= ST_ACK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (!i_ext_req) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_commit = (r_state == ST_WRITE);

    bat_amateur_load_stats #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_stats (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (i_clr_stats),
        .i_inc        (w_commit),
        .i_data       (r_wdata),
        .o_word_count (o_word_count),
        .o_checksum   (o_checksum)
    );

    assign o_ext_ack   = r_ack;
    assign o_ext_err   = r_err;
    assign o_ext_rdata = r_rdata;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_we    = r_we;
    assign o_ram_oe    = r_oe;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_bat_amateur_ext_port.sv
// Directed bench for bat_amateur_ext_port with a small behavioural RAM behind the port.
module tb_bat_amateur_ext_port;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          req = 1'b0;
    logic          rw = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ack, err, ram_we, ram_oe, busy;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata, checksum;
    logic [AW-1:0] ram_addr, word_count;

    logic [DW-1:0] mem [0:255];
    int            we_cnt = 0;
    int            oe_cnt = 0;
    int            both_cnt = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    int            lat;
    logic          t_err;
    logic [DW-1:0] t_rd;
    int            we0, oe0;

    always #5 clk = ~clk;

    bat_amateur_ext_port #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .READ_LATENCY  (LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_halt       (halt),
        .i_ext_req    (req),
        .i_ext_rw     (rw),
        .i_ext_addr   (addr),
        .i_ext_wdata  (wdata),
        .o_ext_ack    (ack),
        .o_ext_err    (err),
        .o_ext_rdata  (rdata),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_we     (ram_we),
        .o_ram_oe     (ram_oe),
        .i_ram_rdata  (ram_rdata),
        .i_clr_stats  (clr),
        .o_word_count (word_count),
        .o_checksum   (checksum),
        .o_busy       (busy)
    );

    // Address is held for the whole transaction, so an asynchronous read serves any latency.
    assign ram_rdata = mem[ram_addr[7:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (ram_oe) oe_cnt <= oe_cnt + 1;
        if (ram_we && ram_oe) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 4-phase transaction; lat counts clock edges from REQ sampled to ACK visible.
    task automatic xfer(input logic t_rw, input logic [AW-1:0] t_addr, input logic [DW-1:0] t_wdata,
                        input int hold, input int halt_drop_at, input int clr_at,
                        output int o_lat, output logic o_err, output logic [DW-1:0] o_rd);
        @(negedge clk);
        req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
        o_lat = 0;
        do begin
            @(negedge clk);
            o_lat++;
            clr = (o_lat == clr_at);
            if (o_lat == halt_drop_at) halt = 1'b0;
        end while (!ack && o_lat < 20);
        o_err = err;
        o_rd  = rdata;
        repeat (hold) @(negedge clk);
        if (hold > 0) check("ack_held", 32'(ack), 32'd1);
        req = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        check("ack_drop", 32'({ack, busy}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        @(negedge clk);
        check("rst_ctrl", 32'({ack, err, ram_we, ram_oe, busy}), 32'd0);
        check("rst_stats", {word_count, checksum}, 32'd0);
        rst = 1'b0;
        halt = 1'b1;

        // 1: write 0xBEEF to 0x0010
        @(negedge clk);
        req = 1'b1; rw = 1'b0; addr = 16'h0010; wdata = 16'hBEEF;
        @(negedge clk);
        check("t1_we_pulse", 32'({ram_we, ram_oe, ack}), 32'b100);
        check("t1_ram_addr", 32'(ram_addr), 32'h0010);
        check("t1_ram_wdata", 32'(ram_wdata), 32'hBEEF);
        @(negedge clk);
        check("t1_ack", 32'({ack, err, ram_we}), 32'b100);
        check("t1_count", 32'(word_count), 32'd1);
        check("t1_sum", 32'(checksum), 32'hBEEF);
        req = 1'b0;
        @(negedge clk);
        check("t1_idle", 32'({ack, busy}), 32'd0);
        check("t1_we_total", 32'(we_cnt), 32'd1);

        // 2: read back with latency 3
        we0 = we_cnt; oe0 = oe_cnt;
        xfer(1'b1, 16'h0010, 16'h0000, 0, 0, 0, lat, t_err, t_rd);
        check("t2_lat", 32'(lat), 32'd4);
        check("t2_err", 32'(t_err), 32'd0);
        check("t2_rdata", 32'(t_rd), 32'hBEEF);
        check("t2_oe_once", 32'(oe_cnt - oe0), 32'd1);
        check("t2_no_we", 32'(we_cnt - we0), 32'd0);

        // 3: refused while running
        halt = 1'b0;
        we0 = we_cnt; oe0 = oe_cnt;
        xfer(1'b0, 16'h0011, 16'h1111, 0, 0, 0, lat, t_err, t_rd);
        check("t3_lat", 32'(lat), 32'd1);
        check("t3_err", 32'(t_err), 32'd1);
        check("t3_no_ram", 32'((we_cnt - we0) + (oe_cnt - oe0)), 32'd0);
        check("t3_stats", {word_count, checksum}, {16'd1, 16'hBEEF});

        // 4: checksum wrap, then clear colliding with a write commit
        halt = 1'b1;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("t4_clr", {word_count, checksum}, 32'd0);
        xfer(1'b0, 16'h0020, 16'hFFFF, 0, 0, 0, lat, t_err, t_rd);
        check("t4_lat", 32'(lat), 32'd2);
        xfer(1'b0, 16'h0021, 16'h0002, 0, 0, 0, lat, t_err, t_rd);
        check("t4_wrap", {word_count, checksum}, {16'd2, 16'h0001});
        xfer(1'b0, 16'h0022, 16'h5555, 0, 0, 1, lat, t_err, t_rd);
        check("t4_clr_prio", {word_count, checksum}, 32'd0);
        check("t4_third_err", 32'(t_err), 32'd0);

        // 5: HALT drop during READ_WAIT aborts; EXT_RDATA keeps the last good read
        xfer(1'b1, 16'h0020, 16'h0000, 0, 1, 0, lat, t_err, t_rd);
        check("t5_abort_lat", 32'(lat), 32'd2);
        check("t5_abort_err", 32'(t_err), 32'd1);
        check("t5_rdata_kept", 32'(t_rd), 32'hBEEF);
        halt = 1'b1;
        oe0 = oe_cnt; we0 = we_cnt;
        xfer(1'b1, 16'h0020, 16'h0000, 5, 0, 0, lat, t_err, t_rd);
        check("t5_hold_rdata", 32'(t_rd), 32'hFFFF);
        check("t5_one_access", 32'((oe_cnt - oe0) + (we_cnt - we0)), 32'd1);

        // 6: reset mid-read, then a normal write
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 16'h0021;
        @(negedge clk);
        check("t6_busy", 32'({busy, ram_oe}), 32'b11);
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", 32'({ack, err, ram_we, ram_oe, busy}), 32'd0);
        check("t6_rst_bus", {ram_addr, rdata}, 32'd0);
        check("t6_rst_stats", {word_count, checksum}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 16'h0030, 16'h1234, 0, 0, 0, lat, t_err, t_rd);
        check("t6_wr_lat", 32'(lat), 32'd2);
        check("t6_wr_err", 32'(t_err), 32'd0);
        check("t6_stats", {word_count, checksum}, {16'd1, 16'h1234});
        xfer(1'b1, 16'h0030, 16'h0000, 0, 0, 0, lat, t_err, t_rd);
        check("t6_rd", 32'(t_rd), 32'h1234);

        check("strobe_excl", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
